output_grant_engine: RTL

Parametrised, synthesizable output-arbiter grant engine for one input port of the Exanet VC switch. It replaces the fixed-delay testbench granter. It accepts the input's selected VC request, waits a mode-dependent delay, then checks downstream credit for the destination (output, VC). It issues a one-hot output grant and holds it until the packet's `last` beat. It sits between the input VC arbiter and the crossbar/output stage, and is also used as a bench model in random-delay mode.

---
 rtl/output_grant_pkg.sv | 24 ++
 rtl/grant_lfsr.sv | 28 ++
 rtl/output_grant_engine.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/output_grant_pkg.sv
// Shared definitions for the output grant engine.
//   grant_state_t : IDLE / WAITING / GRANTED
//   MODE_*        : delay_mode encodings
//   LFSR_TAPS     : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   lfsr_step     : one right-shift Galois step
package output_grant_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    GRANTED = 2'd2
  } grant_state_t;

  localparam int MODE_ZERO  = 0;
  localparam int MODE_FIXED = 1;
  localparam int MODE_RAND  = 2;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] value);
    return (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/grant_lfsr.sv
// Free-running 16-bit Galois LFSR used to draw pseudo-random grant delays.
// Ports:
//   clk        : clock
//   resetn     : asynchronous active-low reset, reloads seed
//   lfsr_value : current LFSR state
module grant_lfsr
  import output_grant_pkg::*;
#(
  parameter logic [15:0] seed = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] lfsr_value
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_reg <= seed;
    end else begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign lfsr_value = lfsr_reg;

endmodule

// File: rtl/output_grant_engine.sv
// Output grant engine for one switch input port. Accepts the selected VC
// request, waits a mode-dependent delay, checks downstream credit for the
// latched (output, VC) and holds a one-hot output grant until `last`.
// Ports:
//   clk, resetn               : clock, asynchronous active-low reset
//   selected_request          : per-output VC request vector
//   output_dest/output_vc_dest: destination of the current request
//   last                      : final beat of the granted packet
//   credit_avail              : credit bits, index dest*vc_total+vc
//   grant_from_output_arbiter : one-hot output grant
//   grant_vc                  : VC of the active grant (0 when idle)
//   busy                      : engine not idle
//   grant_cnt                 : saturating count of granted packets
module output_grant_engine
  import output_grant_pkg::*;
#(
  parameter int          vc_num      = 3,
  parameter int          prio_num    = 2,
  parameter int          output_num  = 8,
  parameter int          delay_mode  = 1,
  parameter int          fixed_delay = 3,
  parameter int          delay_bits  = 2,
  parameter logic [15:0] lfsr_seed   = 16'hACE1,
  localparam int         vc_total    = vc_num * prio_num,
  localparam int         dw          = $clog2(output_num),
  localparam int         vw          = $clog2(vc_total)
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic [output_num-1:0][vc_total-1:0]  selected_request,
  input  logic [dw-1:0]                        output_dest,
  input  logic [vw-1:0]                        output_vc_dest,
  input  logic                                 last,
  input  logic [output_num*vc_total-1:0]       credit_avail,
  output logic [output_num-1:0]                grant_from_output_arbiter,
  output logic [vw-1:0]                        grant_vc,
  output logic                                 busy,
  output logic [15:0]                          grant_cnt
);

  localparam int cw = output_num * vc_total;
  // One spare index bit so the padded credit vector is always strictly wider
  // than the real one; out-of-range VC codes then read as "no credit".
  localparam int iw = $clog2(cw + 1);

  grant_state_t          state_reg, state_next;
  logic [delay_bits-1:0] cnt_reg, cnt_next;
  logic [dw-1:0]         dest_reg, dest_next;
  logic [vw-1:0]         vc_reg, vc_next;
  logic [15:0]           grant_cnt_reg;

  logic [15:0]           lfsr_value;
  logic [delay_bits-1:0] delay_val;
  logic [(2**iw)-1:0]    credit_ext;
  logic [iw-1:0]         live_idx, q_idx;
  logic                  req_any, live_credit, q_credit;
  logic                  grant_en, first_grant;
  logic [dw-1:0]         grant_dest;
  logic [vw-1:0]         grant_vc_sel;
  logic                  unused_lfsr_bits;

  grant_lfsr #(.seed(lfsr_seed)) u_lfsr (
    .clk        (clk),
    .resetn     (resetn),
    .lfsr_value (lfsr_value)
  );

  assign unused_lfsr_bits = ^lfsr_value[15:delay_bits];
  assign req_any          = |selected_request;

  always_comb begin
    if (delay_mode == MODE_RAND) begin
      delay_val = lfsr_value[delay_bits-1:0];
    end else if (delay_mode == MODE_FIXED) begin
      delay_val = delay_bits'(fixed_delay);
    end else begin
      delay_val = '0;
    end
  end

  always_comb begin
    credit_ext          = '0;
    credit_ext[cw-1:0]  = credit_avail;
  end

  assign live_idx    = iw'(output_dest) * iw'(vc_total) + iw'(output_vc_dest);
  assign q_idx       = iw'(dest_reg) * iw'(vc_total) + iw'(vc_reg);
  assign live_credit = credit_ext[live_idx];
  assign q_credit    = credit_ext[q_idx];

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    dest_next    = dest_reg;
    vc_next      = vc_reg;
    grant_en     = 1'b0;
    first_grant  = 1'b0;
    grant_dest   = dest_reg;
    grant_vc_sel = vc_reg;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          dest_next = output_dest;
          vc_next   = output_vc_dest;
          if (delay_val == '0) begin
            if (live_credit) begin
              // Zero-delay grant bypasses the latch and uses the live target.
              grant_en     = 1'b1;
              first_grant  = 1'b1;
              grant_dest   = output_dest;
              grant_vc_sel = output_vc_dest;
              state_next   = last ? IDLE : GRANTED;
            end else begin
              cnt_next   = '0;
              state_next = WAITING;
            end
          end else begin
            cnt_next   = delay_val - 1'b1;
            state_next = WAITING;
          end
        end
      end
      WAITING: begin
        // Withdrawal takes priority over a grant that would fire this cycle.
        if (!req_any) begin
          state_next = IDLE;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (q_credit) begin
          grant_en    = 1'b1;
          first_grant = 1'b1;
          state_next  = last ? IDLE : GRANTED;
        end
      end
      GRANTED: begin
        grant_en = 1'b1;
        if (last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      dest_reg      <= '0;
      vc_reg        <= '0;
      grant_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dest_reg  <= dest_next;
      vc_reg    <= vc_next;
      if (first_grant && (grant_cnt_reg != 16'hFFFF)) begin
        grant_cnt_reg <= grant_cnt_reg + 16'd1;
      end
    end
  end

  // Gating with resetn keeps the zero-delay combinational grant low while
  // reset is held.
  genvar gi;
  generate
    for (gi = 0; gi < output_num; gi++) begin : g_grant
      assign grant_from_output_arbiter[gi] =
        grant_en && resetn && (grant_dest == dw'(gi));
    end
  endgenerate

  assign grant_vc  = (grant_en && resetn) ? grant_vc_sel : '0;
  assign busy      = (state_reg != IDLE);
  assign grant_cnt = grant_cnt_reg;

endmodule
